pwm_duty_ctrl: RTL and testbench

PWM duty-cycle controller driven by debounced push-button pulses. It takes single-cycle increment, decrement and enable-toggle pulses from the button debouncers and maintains a saturating duty setting. It generates the PWM waveform from a free-running period counter. Duty changes are staged in a shadow register and committed only at period boundaries, so the output never produces a truncated or glitched period.

---
 rtl/pwm_duty_ctrl.sv | 115 +++++++++++
 tb/tb_pwm_duty_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ctrl.sv
// PWM duty-cycle controller: button-driven shadow duty, committed at period boundaries.
// Define PWM_DUTY_WRAP_EN to make inc/dec wrap around instead of saturating.
module pwm_duty_ctrl #(
    parameter int PERIOD    = 1000,
    parameter int STEP      = 100,
    parameter int INIT_DUTY = 500,
    parameter int CW        = $clog2(PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_pulse,
    input  logic          dec_pulse,
    input  logic          en_pulse,
    output logic          pwm_out,
    output logic [CW-1:0] duty,
    output logic [CW-1:0] duty_active,
    output logic          active,
    output logic          period_start
);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    localparam logic [CW:0]   PERIOD_X = (CW + 1)'(PERIOD);
    localparam logic [CW:0]   STEP_X   = (CW + 1)'(STEP);
    localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);
    localparam logic [CW-1:0] INIT_D   = CW'(INIT_DUTY);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] duty_q, duty_d;
    logic [CW-1:0] duty_active_q, duty_active_d;
    logic          pwm_q, pwm_d;

    // One extra bit so duty+STEP can be compared against PERIOD without overflow.
    logic [CW:0] duty_x;
    logic [CW:0] inc_sum;

    assign duty_x  = {1'b0, duty_q};
    assign inc_sum = duty_x + STEP_X;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        duty_d = duty_q;
        if (inc_pulse && !dec_pulse) begin
`ifdef PWM_DUTY_WRAP_EN
            duty_d = (inc_sum > PERIOD_X) ? '0 : inc_sum[CW-1:0];
`else
            duty_d = (inc_sum > PERIOD_X) ? PERIOD_X[CW-1:0] : inc_sum[CW-1:0];
`endif
        end else if (dec_pulse && !inc_pulse) begin
`ifdef PWM_DUTY_WRAP_EN
            duty_d = (duty_x < STEP_X) ? PERIOD_X[CW-1:0] : duty_q - STEP_X[CW-1:0];
`else
            duty_d = (duty_x < STEP_X) ? '0 : duty_q - STEP_X[CW-1:0];
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        duty_active_d = duty_active_q;
        pwm_d         = (state_q == ST_RUN) && (cnt_q < duty_active_q);
        case (state_q)
            ST_RUN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = '0;
                    duty_active_d = duty_d;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Leaving RUN abandons the partial period immediately.
                if (en_pulse) begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                end
            end
            default: begin
                cnt_d = '0;
                if (en_pulse) begin
                    state_d       = ST_RUN;
                    duty_active_d = duty_d;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            duty_q        <= INIT_D;
            duty_active_q <= INIT_D;
            pwm_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            duty_q        <= duty_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign duty         = duty_q;
    assign duty_active  = duty_active_q;
    assign active       = (state_q == ST_RUN);
    // Gated by reset so the pulse reads low while reset is held.
    assign period_start = rst && (state_q == ST_RUN) && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Self-checking bench for pwm_duty_ctrl (PERIOD=10, STEP=2, INIT_DUTY=4):
// table vectors, directed corner sequences and random pulses against a reference model.
module tb_pwm_duty_ctrl;

    localparam int P  = 10;
    localparam int S  = 2;
    localparam int I  = 4;
    localparam int CW = $clog2(P + 1);

    logic          clk;
    logic          rst;
    logic          inc_pulse;
    logic          dec_pulse;
    logic          en_pulse;
    logic          pwm_out;
    logic [CW-1:0] duty;
    logic [CW-1:0] duty_active;
    logic          active;
    logic          period_start;

    pwm_duty_ctrl #(
        .PERIOD   (P),
        .STEP     (S),
        .INIT_DUTY(I),
        .CW       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inc_pulse   (inc_pulse),
        .dec_pulse   (dec_pulse),
        .en_pulse    (en_pulse),
        .pwm_out     (pwm_out),
        .duty        (duty),
        .duty_active (duty_active),
        .active      (active),
        .period_start(period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: run flag, phase within period, shadow and committed duty.
    bit m_run;
    int m_phase;
    int m_duty;
    int m_dact;
    int m_pwm;

    typedef struct {
        bit inc;
        bit dec;
        bit en;
        int exp_duty_sat;
        int exp_duty_wrap;
        bit exp_active;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int next_duty(input int d, input bit inc, input bit dec);
        if (inc == dec) return d;
`ifdef PWM_DUTY_WRAP_EN
        if (inc) return (d == P) ? 0 : d + S;
        return (d == 0) ? P : d - S;
`else
        if (inc) return (d + S > P) ? P : d + S;
        return (d - S < 0) ? 0 : d - S;
`endif
    endfunction

    task automatic model_reset();
        m_run   = 1'b1;
        m_phase = 0;
        m_duty  = I;
        m_dact  = I;
        m_pwm   = 0;
    endtask

    task automatic model_clock(input bit inc, input bit dec, input bit en);
        int nd;
        nd    = next_duty(m_duty, inc, dec);
        m_pwm = (m_run && m_phase < m_dact) ? 1 : 0;
        if (m_run) begin
            m_phase = (m_phase + 1) % P;
            if (m_phase == 0) m_dact = nd;
            if (en) begin
                m_run   = 1'b0;
                m_phase = 0;
            end
        end else if (en) begin
            m_run   = 1'b1;
            m_phase = 0;
            m_dact  = nd;
        end
        m_duty = nd;
    endtask

    task automatic compare_all();
        check("duty", int'(duty), m_duty);
        check("duty_active", int'(duty_active), m_dact);
        check("active", int'(active), int'(m_run));
        check("pwm_out", int'(pwm_out), m_pwm);
        check("period_start", int'(period_start), (rst && m_run && m_phase == 0) ? 1 : 0);
    endtask

    task automatic step(input bit inc, input bit dec, input bit en);
        inc_pulse = inc;
        dec_pulse = dec;
        en_pulse  = en;
        @(posedge clk);
        model_clock(inc, dec, en);
        #1;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        en_pulse  = 1'b0;
        compare_all();
    endtask

    task automatic wait_phase(input int ph);
        int g;
        g = 0;
        while (m_phase != ph && g < 3 * P) begin
            step(0, 0, 0);
            g++;
        end
        if (m_phase != ph) timeout_fail("wait_phase");
    endtask

    // Waits for the next period_start, then checks the D-high / (P-D)-low shape.
    task automatic measure_period(input string name, input int d);
        int g;
        g = 0;
        while (!period_start && g < 2 * P) begin
            step(0, 0, 0);
            g++;
        end
        if (!period_start) timeout_fail(name);
        for (int i = 0; i < P; i++) begin
            step(0, 0, 0);
            check(name, int'(pwm_out), (i < d) ? 1 : 0);
        end
    endtask

    task automatic drive_duty_to(input int target);
        int g;
        g = 0;
        while (m_duty != target && g < 12) begin
            step(m_duty < target, m_duty > target, 0);
            g++;
        end
        if (m_duty != target) timeout_fail("drive_duty");
    endtask

    // Asserts reset between clock edges and checks the asynchronous clear.
    task automatic pulse_reset();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_duty", int'(duty), I);
        check("rst_duty_active", int'(duty_active), I);
        check("rst_active", int'(active), 1);
        check("rst_pwm_out", int'(pwm_out), 0);
        check("rst_period_start", int'(period_start), 0);
        #2;
        rst = 1'b1;
        #1;
        compare_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 6, 6, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 6, 6, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4, 4, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 4, 4, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 2, 2, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 0, 10, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 2, 0, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 4, 2, 1'b1};

        rst       = 1'b0;
        inc_pulse = 1'b0;
        dec_pulse = 1'b0;
        en_pulse  = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b1;
        #1;
        compare_all();

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].inc, vecs[i].dec, vecs[i].en);
`ifdef PWM_DUTY_WRAP_EN
            check($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty_wrap);
`else
            check($sformatf("vec%0d_duty", i), int'(duty), vecs[i].exp_duty_sat);
`endif
            check($sformatf("vec%0d_active", i), int'(active), int'(vecs[i].exp_active));
        end

        // Free-run after reset.
        pulse_reset();
        measure_period("wave_init", 4);
        measure_period("wave_init2", 4);

        // Mid-period change is deferred to the wrap.
        wait_phase(3);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        check("mid_duty", int'(duty), 10);
        check("mid_duty_active_hold", int'(duty_active), 4);
        wait_phase(P - 1);
        check("mid_before_wrap", int'(duty_active), 4);
        step(0, 0, 0);
        check("mid_after_wrap", int'(duty_active), 10);
        measure_period("wave_full", 10);

        // Saturation at zero.
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        check("sat_zero", int'(duty), 0);
        measure_period("wave_zero", 0);
        step(0, 1, 0);
`ifdef PWM_DUTY_WRAP_EN
        check("dec_below_zero", int'(duty), 10);
`else
        check("dec_below_zero", int'(duty), 0);
`endif

        // Simultaneous inc and dec.
        drive_duty_to(6);
        step(1, 1, 0);
        check("both_pulses", int'(duty), 6);

        // Enable toggle mid-period.
        drive_duty_to(4);
        wait_phase(2);
        step(0, 0, 1);
        check("off_active", int'(active), 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            check("off_pwm", int'(pwm_out), 0);
            check("off_period_start", int'(period_start), 0);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        check("off_inc_duty", int'(duty), 8);
        step(0, 0, 1);
        check("restart_active", int'(active), 1);
        check("restart_duty_active", int'(duty_active), 8);
        check("restart_period_start", int'(period_start), 1);
        measure_period("wave_restart", 8);

        // Reset in the middle of a period.
        wait_phase(7);
        pulse_reset();
        measure_period("wave_after_reset", 4);

        // Random pulses against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 30) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
